// File: rtl/vdp_super_res_writer.sv
// Packs CPU bytes into super-res VRAM words, queues them, and drains one per AP slot (cx[1:0]==2'b10).
// Optional build macro SUPER_RES_WRITER_PARTIAL_FLUSH_EN: address loads flush a partial word.
module vdp_super_res_writer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vdp_super,
   input  logic        super_color,
   input  logic        super_mid,
   input  logic [10:0] cx,
   input  logic        addr_wr,
   input  logic [16:0] addr_in,
   input  logic        byte_wr,
   input  logic [7:0]  byte_in,
   output logic        cpu_wait,
   output logic        overflow,
   output logic        vram_wr_en,
   output logic [16:0] vram_wr_addr,
   output logic [31:0] vram_wr_data,
   output logic [3:0]  vram_wr_be
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic        w_active, w_mid, w_last, w_mode_sw, w_push, w_pop, w_full;
   logic [1:0]  w_lane;
   logic [31:0] w_word_next;
   logic        w_unused;

   logic [16:0] r_wr_ptr;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_word;
   logic        r_mode_mid;
   logic        r_overflow;
   logic        r_pend_valid;
   logic [16:0] r_pend_addr;
   logic [31:0] r_pend_data;
   logic [3:0]  r_pend_be;

   logic [16:0] r_fifo_addr [FIFO_DEPTH];
   logic [31:0] r_fifo_data [FIFO_DEPTH];
   logic [3:0]  r_fifo_be   [FIFO_DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_count;

   logic        r_wr_en;
   logic [16:0] r_wr_addr;
   logic [31:0] r_wr_data;
   logic [3:0]  r_wr_be;

   // Colour mode takes priority when both mode bits are set.
   assign w_active  = vdp_super & (super_color | super_mid);
   assign w_mid     = ~super_color;
   assign w_mode_sw = (w_mid != r_mode_mid);
   assign w_last    = w_mid ? (r_byte_cnt == 2'd3) : (r_byte_cnt == 2'd2);
   assign w_full    = (r_count == FULL_CNT);
   assign w_push    = r_pend_valid;
   assign w_pop     = w_active & (cx[1:0] == 2'b01) & (r_count != '0);
   assign w_unused  = ^{cx[10:2], addr_in[0]};

   // Byte lane for the next byte: colour R,G,B -> 2,1,0; mid lo,hi,lo,hi -> 2,3,0,1.
   always_comb begin
      w_lane = 2'd0;
      case ({w_mid, r_byte_cnt})
         3'b000:  w_lane = 2'd2;
         3'b001:  w_lane = 2'd1;
         3'b010:  w_lane = 2'd0;
         3'b100:  w_lane = 2'd2;
         3'b101:  w_lane = 2'd3;
         3'b110:  w_lane = 2'd0;
         3'b111:  w_lane = 2'd1;
         default: w_lane = 2'd0;
      endcase
      w_word_next = r_word;
      w_word_next[w_lane*8 +: 8] = byte_in;
   end

`ifdef SUPER_RES_WRITER_PARTIAL_FLUSH_EN
   logic [3:0] w_part_be;
   assign w_part_be = w_mid ? {r_byte_cnt >= 2'd2, 1'b1, 1'b0, r_byte_cnt == 2'd3}
                            : {1'b0, 1'b1, r_byte_cnt >= 2'd2, 1'b0};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_byte_cnt   <= '0;
         r_word       <= '0;
         r_mode_mid   <= 1'b0;
         r_overflow   <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_data  <= '0;
         r_pend_be    <= '0;
      end else begin
         r_mode_mid   <= w_mid;
         r_pend_valid <= 1'b0;
         if (!w_active) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_overflow <= 1'b0;
         end else if (addr_wr) begin
            r_wr_ptr   <= {addr_in[16:1], 1'b0};
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_overflow <= 1'b0;
`ifdef SUPER_RES_WRITER_PARTIAL_FLUSH_EN
            if (r_byte_cnt != 2'd0) begin
               if (w_full) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_pend_valid <= 1'b1;
                  r_pend_addr  <= r_wr_ptr;
                  r_pend_data  <= r_word;
                  r_pend_be    <= w_part_be;
               end
            end
`endif
         end else if (w_mode_sw) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
         end else if (byte_wr) begin
            if (w_full) begin
               r_overflow <= 1'b1;
            end else if (w_last) begin
               r_pend_valid <= 1'b1;
               r_pend_addr  <= r_wr_ptr;
               r_pend_data  <= w_word_next;
               r_pend_be    <= 4'hF;
               r_wr_ptr     <= r_wr_ptr + 17'd2;
               r_byte_cnt   <= '0;
               r_word       <= '0;
            end else begin
               r_word     <= w_word_next;
               r_byte_cnt <= r_byte_cnt + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wp] <= r_pend_addr;
         r_fifo_data[r_wp] <= r_pend_data;
         r_fifo_be[r_wp]   <= r_pend_be;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_be   <= '0;
      end else if (!w_active) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_be   <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop) begin
            r_rp      <= r_rp + PW'(1);
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_fifo_addr[r_rp];
            r_wr_data <= r_fifo_data[r_rp];
            r_wr_be   <= r_fifo_be[r_rp];
         end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_be   <= '0;
         end
         // Simultaneous push and pop leaves the occupancy unchanged, even when full.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign cpu_wait     = w_active & w_full;
   assign overflow     = r_overflow;
   assign vram_wr_en   = r_wr_en;
   assign vram_wr_addr = r_wr_addr;
   assign vram_wr_data = r_wr_data;
   assign vram_wr_be   = r_wr_be;

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Bench for vdp_super_res_writer: directed scenarios plus random bursts against a byte-list model.
module tb_vdp_super_res_writer;
   logic        clk = 1'b0;
   logic        reset;
   logic        vdp_super, super_color, super_mid;
   logic [10:0] cx;
   logic        cx_run;
   logic        addr_wr;
   logic [16:0] addr_in;
   logic        byte_wr;
   logic [7:0]  byte_in;
   logic        cpu_wait, overflow, vram_wr_en;
   logic [16:0] vram_wr_addr;
   logic [31:0] vram_wr_data;
   logic [3:0]  vram_wr_be;

   int checks = 0;
   int errors = 0;
   int n_writes = 0;
   int cyc = 0;

   logic [52:0] exp_q[$];
   logic [52:0] mon_e;
   logic [16:0] m_ptr;
   logic        m_mid;
   logic [7:0]  m_bytes[$];

   vdp_super_res_writer #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .vdp_super(vdp_super), .super_color(super_color),
      .super_mid(super_mid), .cx(cx), .addr_wr(addr_wr), .addr_in(addr_in),
      .byte_wr(byte_wr), .byte_in(byte_in), .cpu_wait(cpu_wait), .overflow(overflow),
      .vram_wr_en(vram_wr_en), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data),
      .vram_wr_be(vram_wr_be)
   );

   // Clock, and a free-running pixel counter that behaves like the display's register.
   always #5 clk = ~clk;
   always @(posedge clk) if (cx_run) cx <= cx + 11'd1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word as the display expects it: colour {00,R,G,B}; mid {hi0,lo0,hi1,lo1}.
   function automatic logic [52:0] model_word(input logic full);
      logic [7:0]  p [4];
      int          n;
      logic [31:0] d;
      logic [3:0]  be;
      n = m_bytes.size();
      for (int i = 0; i < 4; i++) p[i] = (i < n) ? m_bytes[i] : 8'h00;
      if (m_mid) begin
         d  = {p[1], p[0], p[3], p[2]};
         be = {n >= 2, n >= 1, n >= 4, n >= 3};
      end else begin
         d  = {8'h00, p[0], p[1], p[2]};
         be = {1'b0, n >= 1, n >= 2, n >= 3};
      end
      if (full) be = 4'hF;
      return {m_ptr, d, be};
   endfunction

   // Scoreboard: every write must land in an AP slot and match the next expected word.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (vram_wr_en === 1'b1) begin
         n_writes++;
         chk("ap_slot", 64'(cx[1:0]), 64'(2'b10));
         mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         chk("write_word", 64'({vram_wr_addr, vram_wr_data, vram_wr_be}), 64'(mon_e));
      end
   end

   task automatic set_mode(input logic c, input logic m);
      @(negedge clk);
      super_color = c;
      super_mid   = m;
      if (m_mid != !c) m_bytes.delete();
      m_mid = !c;
   endtask

   task automatic load_addr(input logic [16:0] a);
      @(negedge clk);
      addr_wr = 1'b1;
      addr_in = a;
`ifdef SUPER_RES_WRITER_PARTIAL_FLUSH_EN
      if (m_bytes.size() != 0 && !cpu_wait) exp_q.push_back(model_word(1'b0));
`endif
      @(negedge clk);
      addr_wr = 1'b0;
      m_ptr = {a[16:1], 1'b0};
      m_bytes.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit obey);
      int t;
      bit accepted;
      @(negedge clk);
      t = 0;
      while (obey && cpu_wait && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (obey) chk("cpu_wait_bound", 64'(t < 200), 64'd1);
      accepted = !cpu_wait;
      byte_wr = 1'b1;
      byte_in = b;
      @(negedge clk);
      byte_wr = 1'b0;
      if (accepted) begin
         m_bytes.push_back(b);
         if (m_bytes.size() == (m_mid ? 4 : 3)) begin
            exp_q.push_back(model_word(1'b1));
            m_ptr = m_ptr + 17'd2;
            m_bytes.delete();
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int w0, nw, nb, found;
      int times [4];
      logic c, m;
      reset = 1'b1; vdp_super = 1'b1; super_color = 1'b0; super_mid = 1'b0;
      cx = '0; cx_run = 1'b1; addr_wr = 1'b0; addr_in = '0; byte_wr = 1'b0; byte_in = '0;
      m_ptr = '0; m_mid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_en", 64'(vram_wr_en), 64'd0);
      chk("rst_addr", 64'(vram_wr_addr), 64'd0);
      chk("rst_data", 64'(vram_wr_data), 64'd0);
      chk("rst_be", 64'(vram_wr_be), 64'd0);
      chk("rst_wait", 64'(cpu_wait), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      reset = 1'b0;

      // Colour word, must appear within a few clocks.
      set_mode(1'b1, 1'b0);
      load_addr(17'h00100);
      send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
      wait_drain(8);

      // Mid mode, two identical words.
      set_mode(1'b0, 1'b1);
      load_addr(17'h00000);
      for (int k = 0; k < 2; k++) begin
         send_byte(8'h34, 1); send_byte(8'h12, 1); send_byte(8'h78, 1); send_byte(8'h56, 1);
      end
      wait_drain(30);

      // Fill with cx frozen, overflow on the extra byte, then drain 4 clocks apart.
      set_mode(1'b1, 1'b0);
      load_addr(17'h00200);
      @(negedge clk);
      cx_run = 1'b0;
      cx = '0;
      for (int k = 0; k < 12; k++) send_byte(8'(8'h40 + k), 1);
      repeat (2) @(negedge clk);
      chk("full_wait", 64'(cpu_wait), 64'd1);
      chk("full_ovf_before", 64'(overflow), 64'd0);
      send_byte(8'h99, 0);
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("full_wait_held", 64'(cpu_wait), 64'd1);
      cx_run = 1'b1;
      for (int k = 0; k < 4; k++) begin
         found = 0;
         for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #2;
            if (vram_wr_en) begin found = 1; break; end
         end
         chk("drain_found", 64'(found), 64'd1);
         times[k] = cyc;
      end
      for (int k = 1; k < 4; k++) chk("drain_gap", 64'(times[k] - times[k-1]), 64'd4);
      wait_drain(10);
      send_byte(8'hA1, 1); send_byte(8'hA2, 1); send_byte(8'hA3, 1);
      wait_drain(10);
      load_addr(17'h00204);
      chk("ovf_clear", 64'(overflow), 64'd0);

      // Pointer wrap.
      load_addr(17'h1FFFE);
      for (int k = 0; k < 6; k++) send_byte(8'(8'hC0 + k), 1);
      wait_drain(20);

      // Partial word on address load.
      set_mode(1'b0, 1'b1);
      load_addr(17'h00300);
      w0 = n_writes;
      send_byte(8'hAB, 1);
      load_addr(17'h00400);
      wait_drain(12);
      repeat (10) @(negedge clk);
`ifdef SUPER_RES_WRITER_PARTIAL_FLUSH_EN
      chk("partial_writes", 64'(n_writes - w0), 64'd1);
`else
      chk("partial_writes", 64'(n_writes - w0), 64'd0);
`endif

      // Inactive: nothing asserted.
      @(negedge clk);
      vdp_super = 1'b0;
      repeat (3) @(negedge clk);
      chk("inactive_wait", 64'(cpu_wait), 64'd0);
      chk("inactive_en", 64'(vram_wr_en), 64'd0);
      vdp_super = 1'b1;

      // Random bursts of whole words.
      for (int b = 0; b < 6; b++) begin
         c = 1'($urandom_range(0, 1));
         m = c ? 1'($urandom_range(0, 1)) : 1'b1;
         set_mode(c, m);
         load_addr(17'($urandom_range(0, 17'h1FFFF)));
         nw = $urandom_range(1, 6);
         nb = nw * (c ? 3 : 4);
         for (int k = 0; k < nb; k++) send_byte(8'($urandom_range(0, 255)), 1);
      end
      wait_drain(400);
      chk("rand_ovf", 64'(overflow), 64'd0);

      // Reset while a write is on the bus.
      set_mode(1'b1, 1'b0);
      load_addr(17'h00500);
      send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
      found = 0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #2;
         if (vram_wr_en) begin found = 1; break; end
      end
      chk("mid_drain_en", 64'(found), 64'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_en", 64'(vram_wr_en), 64'd0);
      chk("async_rst_addr", 64'(vram_wr_addr), 64'd0);
      chk("async_rst_data", 64'(vram_wr_data), 64'd0);
      chk("async_rst_be", 64'(vram_wr_be), 64'd0);
      exp_q.delete();
      m_bytes.delete();
      m_ptr = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      w0 = n_writes;
      repeat (12) @(negedge clk);
      chk("post_rst_writes", 64'(n_writes - w0), 64'd0);
      chk("post_rst_wait", 64'(cpu_wait), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
